// File: rtl/tdes_uart_pkg.sv
// Shared definitions for the tdes serial link UART blocks.
// Contents:
//   rx_state_e      receiver state encoding (IDLE, START, DATA, STOP, BREAK)
//   OVERSAMPLE_DEF  default sys_clk cycles per serial bit
//   DATA_BITS_DEF   default data bits per frame
//   HALF_BIT        half a bit period at the default oversample rate
//   half_bit()      half a bit period for an arbitrary oversample rate
package tdes_uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;
  localparam int HALF_BIT       = OVERSAMPLE_DEF / 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int half_bit(input int oversample);
    return oversample / 2;
  endfunction

endpackage

// File: rtl/tdes_uart_rx_if.sv
// Received-byte bus of the tdes UART receiver.
// Signals:
//   rec_dataH   last correctly framed byte
//   rec_readyH  one-cycle strobe, new byte valid on rec_dataH
//   rec_errH    one-cycle strobe, framing error (stop bit low)
// Modports:
//   master  the receiver, drives the bus
//   slave   the consumer of received bytes
interface tdes_uart_rx_if
  import tdes_uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);

  logic [DATA_BITS-1:0] rec_dataH;
  logic                 rec_readyH;
  logic                 rec_errH;

  modport master (
    output rec_dataH,
    output rec_readyH,
    output rec_errH
  );

  modport slave (
    input rec_dataH,
    input rec_readyH,
    input rec_errH
  );

endinterface

// File: rtl/tdes_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops load RESET_VAL
//   d      asynchronous input
//   q      synchronized output, two clk cycles behind d
// RESET_VAL defaults to 1 so an idle-high serial line does not look like
// a start bit straight after reset.
module tdes_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain
  // into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tdes_uart_rx.sv
// 8N1 serial byte receiver for the triple-DES serial link.
// Ports:
//   sys_clk     oversampling clock, OVERSAMPLE x baud rate
//   sys_rst_l   asynchronous active-low reset
//   uart_dataH  serial line, idle high, asynchronous to sys_clk
//   rx_bus      received-byte bus (rec_dataH, rec_readyH, rec_errH)
// The line is synchronized, the start bit is verified at its middle, then
// every following bit is sampled one full bit period later. A good stop bit
// publishes the byte with a one-cycle ready strobe; a low stop bit raises a
// one-cycle error strobe and the receiver waits for the line to return high
// before hunting for the next start bit.
module tdes_uart_rx
  import tdes_uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic            sys_clk,
  input  logic            sys_rst_l,
  input  logic            uart_dataH,
  tdes_uart_rx_if.master  rx_bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Tick at which the middle of the start bit is reached, and the tick that
  // ends a full bit period measured from the previous sample point.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit(OVERSAMPLE) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic [BIT_W-1:0]     bit_q,   bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 ready_q, ready_d;
  logic                 err_q,   err_d;

  tdes_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_l),
    .d     (uart_dataH),
    .q     (rx_s)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    ready_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
          end else begin
            // High again at mid start bit: a glitch, not a frame.
            state_d = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // LSB arrives first, so shifting in at the MSB leaves bit 0 in the
          // LSB once all data bits are in.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ready_d = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = BREAK;
          end
        end
      end

      BREAK: begin
        // A line stuck low must not be mistaken for a new start bit.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the shift register is reset along with the control flops; it is a
  // handful of bits, and a known value keeps reset behaviour deterministic.
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign rx_bus.rec_dataH  = data_q;
  assign rx_bus.rec_readyH = ready_q;
  assign rx_bus.rec_errH   = err_q;

endmodule

// File: tb/tb_tdes_uart_rx.sv
// Self-checking bench for tdes_uart_rx.
// A serial driver produces 8N1 frames from a bit period in time units; each
// frame's expected outcome (a byte to be delivered, or a framing error) is
// recorded when the frame starts. A monitor on the falling clock edge
// matches every strobe against those expectations and checks the
// start-bit-to-ready latency of nominal-rate frames.
module tb_tdes_uart_rx;

  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int CLK_T   = 10;
  localparam int BIT_T   = OS * CLK_T;
  localparam int LATENCY = 3 + OS / 2 + (DB + 1) * OS;

  logic sys_clk    = 1'b0;
  logic sys_rst_l  = 1'b0;
  logic uart_dataH = 1'b1;

  tdes_uart_rx_if #(.DATA_BITS(DB)) rx_bus ();

  tdes_uart_rx #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_l  (sys_rst_l),
    .uart_dataH (uart_dataH),
    .rx_bus     (rx_bus)
  );

  always #(CLK_T / 2) sys_clk = ~sys_clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int cyc       = 0;
  int fall_cyc  = 0;
  bit lat_armed = 1'b0;
  int got_ready = 0;
  int got_err   = 0;
  int exp_ready = 0;
  int exp_err   = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] last_good = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Strobe monitor.
  always @(negedge sys_clk) begin
    if (rx_bus.rec_readyH || rx_bus.rec_errH)
      check("strobe_exclusive", 32'(rx_bus.rec_readyH & rx_bus.rec_errH), 0);
    if (rx_bus.rec_readyH) begin
      got_ready++;
      check("ready_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0)
        check("rx_byte", 32'(rx_bus.rec_dataH), 32'(exp_q.pop_front()));
      if (lat_armed) begin
        int diff;
        diff = cyc - fall_cyc;
        if (diff < LATENCY - 1 || diff > LATENCY + 1)
          $display("FAIL latency_cycles got=%0d expected=%0d", diff, LATENCY);
        check("latency_in_window", 32'(diff >= LATENCY - 1 && diff <= LATENCY + 1), 1);
      end
    end
    if (rx_bus.rec_errH) got_err++;
  end

  // Drives one frame; the expected outcome is recorded before the line moves
  // because the receiver reports at mid stop bit, before the frame ends.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop, input int bit_t);
    if (stop) begin
      exp_q.push_back(b);
      exp_ready++;
      last_good = b;
    end else begin
      exp_err++;
    end
    lat_armed  = stop && (bit_t == BIT_T);
    uart_dataH = 1'b0;
    fall_cyc   = cyc;
    #(bit_t);
    for (int i = 0; i < DB; i++) begin
      uart_dataH = b[i];
      #(bit_t);
    end
    uart_dataH = stop;
    #(bit_t);
    uart_dataH = 1'b1;
  endtask

  task automatic idle(input int bits);
    uart_dataH = 1'b1;
    #(bits * BIT_T);
  endtask

  // Lets outstanding strobes land, compares totals, then realigns the driver
  // to two time units after a rising edge.
  task automatic checkpoint(input string tag);
    idle(2);
    check({tag, "_ready_count"}, got_ready, exp_ready);
    check({tag, "_err_count"}, got_err, exp_err);
    check({tag, "_data_hold"}, 32'(rx_bus.rec_dataH), 32'(last_good));
    check({tag, "_pending"}, exp_q.size(), 0);
    @(posedge sys_clk);
    #2;
  endtask

  logic [DB-1:0] b2b [7] = '{8'h89, 8'h88, 8'h89, 8'h01, 8'h00, 8'h00, 8'h00};

  initial begin
    #(1_000_000);
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_data", 32'(rx_bus.rec_dataH), 0);
    check("reset_ready", 32'(rx_bus.rec_readyH), 0);
    check("reset_err", 32'(rx_bus.rec_errH), 0);
    @(posedge sys_clk);
    #2;
    sys_rst_l = 1'b1;
    idle(1);
    @(posedge sys_clk);
    #2;

    // Single frame.
    send_frame(8'h88, 1'b1, BIT_T);
    checkpoint("single");

    // Back-to-back frames with no idle gap.
    foreach (b2b[i]) send_frame(b2b[i], 1'b1, BIT_T);
    checkpoint("b2b");

    // Short low glitch: rejected at mid start bit, data keeps 0x00.
    uart_dataH = 1'b0;
    #(4 * CLK_T);
    uart_dataH = 1'b1;
    checkpoint("glitch");

    // Framing error, line held low, then a good frame.
    send_frame(8'h95, 1'b0, BIT_T);
    uart_dataH = 1'b0;
    #(3 * BIT_T);
    idle(2);
    checkpoint("frame_err");
    send_frame(8'hF8, 1'b1, BIT_T);
    checkpoint("after_break");

    // Reset in the middle of data bit 4: frame discarded, outputs cleared.
    fork
      send_frame(8'hA5, 1'b1, BIT_T);
      begin
        #(5 * BIT_T + BIT_T / 2);
        sys_rst_l = 1'b0;
        exp_q.delete();
        exp_ready--;
        last_good = '0;
        lat_armed = 1'b0;
        #1;
        check("midreset_data", 32'(rx_bus.rec_dataH), 0);
        check("midreset_ready", 32'(rx_bus.rec_readyH), 0);
        check("midreset_err", 32'(rx_bus.rec_errH), 0);
      end
    join
    idle(1);
    sys_rst_l = 1'b1;
    idle(1);
    send_frame(8'hDD, 1'b1, BIT_T);
    checkpoint("post_reset");

    // Sender baud skewed by about +3% and -3%.
    send_frame(8'h31, 1'b1, BIT_T + 5);
    checkpoint("skew_slow");
    send_frame(8'h31, 1'b1, BIT_T - 5);
    checkpoint("skew_fast");

    // Random bytes, random gaps, occasional low stop bit.
    for (int n = 0; n < 16; n++) begin
      logic [DB-1:0] b;
      logic          bad;
      b   = DB'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      send_frame(b, !bad, BIT_T);
      if (bad) idle(1 + $urandom_range(0, 1));
      else     idle($urandom_range(0, 2));
    end
    checkpoint("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tdes_uart_rx.md
Name: tdes_uart_rx

Overview:
Serial UART byte receiver for the triple-DES serial link.
- Recovers 8N1 frames from an asynchronous serial line, using a clock that runs at OVERSAMPLE times the baud rate (ref_baud_clock domain).
- Presents each received byte with a one-cycle ready strobe.
- Used both as the host-side monitor of the tdes_top transmit line and as the tdes_top command/data input stage.

Parameters:
OVERSAMPLE, 16, sys_clk cycles per serial bit (even, >=4)
DATA_BITS, 8, data bits per frame, LSB first

Ports:
sys_clk  input  1  oversampling clock, OVERSAMPLE x baud
sys_rst_l  input  1  asynchronous active-low reset
uart_dataH  input  1  serial line, idle high, asynchronous to sys_clk
rec_dataH  output  8  last correctly framed byte
rec_readyH  output  1  one-cycle strobe: new byte valid on rec_dataH
rec_errH  output  1  one-cycle strobe: framing error (stop bit low)

Behaviour:
- Interface: one clock (sys_clk); reset sys_rst_l is asynchronous, active-low. All flops reset asynchronously, everything else is posedge sys_clk.
- Reset values:
  - rec_dataH=8'h00, rec_readyH=0, rec_errH=0.
  - Synchronizer flops=1; state=IDLE; counters=0.
- Input synchronization: 2-flop synchronizer on uart_dataH; the FSM sees only the synchronized line rx_s.
- Tick counter: 0..OVERSAMPLE-1, cleared on every state transition.
- States and transitions:
  - IDLE: rx_s==0 -> START, counter=0.
  - START: at counter==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - 0 -> DATA, bit index=0, counter=0.
    - 1 -> IDLE (glitch rejected, no strobe).
  - DATA: at counter==OVERSAMPLE-1, shift rx_s into the shift register MSB; bits arrive LSB first, so after DATA_BITS samples bit0 is in the LSB. After DATA_BITS samples -> STOP.
  - STOP: at counter==OVERSAMPLE-1, sample rx_s.
    - 1: rec_dataH<=shift register, rec_readyH=1 for exactly one cycle, -> IDLE.
    - 0: rec_errH=1 for one cycle, rec_dataH unchanged, -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. A low line is never treated as a new start.
- Latency: rec_readyH rises on the cycle after the mid-stop-bit sample. That is 3 cycles of synchronizer/IDLE detection + OVERSAMPLE/2 + (DATA_BITS+1)*OVERSAMPLE cycles after the falling edge on uart_dataH.
- Back-to-back frames: a start bit immediately following the stop bit must be received. The receiver returns to IDLE at mid-stop, leaving half a bit of margin.
- rec_dataH holds its value until the next good frame; it is not cleared by the strobe.
- rec_readyH and rec_errH are never high in the same cycle.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values immediately. After release, reception restarts on the next falling edge.
- Line held low from reset release: START verifies low -> frame proceeds normally; a low stop bit yields a framing error, then BREAK.

Decomposition:
- Shared package tdes_uart_pkg: rx state enum (IDLE, START, DATA, STOP, BREAK), OVERSAMPLE and DATA_BITS defaults, HALF_BIT constant.
- One natural sub-module: tdes_sync2, a 2-flop synchronizer with reset value 1, reusable by the transmit side and tdes_top.

Test Plan:
- Reset, then frame 0x88 at 16x oversample -> single rec_readyH pulse, rec_dataH=0x88, rec_errH never set.
- Back-to-back frames 0x89, 0x88, 0x89, 0x01, 0x00, 0x00, 0x00 with no idle gap -> seven ready pulses, data in that order, count=7.
- Line low for 4 ticks, then high -> no strobes, state returns to IDLE, rec_dataH keeps its previous value 0x00.
- Frame 0x95 with stop bit forced low -> rec_errH pulse once, no ready, rec_dataH unchanged. Line held low 3 bit-times, then frame 0xF8 -> ready, rec_dataH=0xF8.
- Assert sys_rst_l low during data bit 4 of frame 0xA5 -> outputs 0 asynchronously. Then send 0xDD -> ready, rec_dataH=0xDD, no error.
- Bit-timing check: sender baud skewed by +/-3% on frame 0x31 -> rec_dataH=0x31. Ready pulse lands exactly at the latency formula, +/-1 cycle at the nominal rate.
